// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray counter interface.
// Helpers operate on MAX_W bits; callers zero-extend narrower counts and truncate the result.
package gray_pkg;

  localparam int unsigned MAX_W = 16;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  // Zero upper bits of a narrower count stay zero, so one MAX_W-wide loop serves every width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// N-bit, SYNC_STAGES-deep synchronizer with async reset; vld_out marks when the chain
// holds real samples rather than reset zeros.
module gray_sync #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] q_out,
  output logic         vld_out
);

  logic [N-1:0]           stage_q [SYNC_STAGES];
  logic [N-1:0]           stage_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic [SYNC_STAGES-1:0] vld_d;

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    vld_d = {vld_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      vld_q <= vld_d;
    end
  end

  assign q_out   = stage_q[SYNC_STAGES-1];
  assign vld_out = vld_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Receive side of the Gray counter interface: synchronize, convert, classify steps, track lock.
// Optional err_count output is compiled in with GRAY_RX_ERR_CNT_EN.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESYNC_CNT  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] gray_in,
  input  logic         clear_err,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic         step_up,
  output logic         step_down,
  output logic         wrap,
  output logic         err,
  output logic         err_sticky,
  output logic         locked
`ifdef GRAY_RX_ERR_CNT_EN
  ,
  output logic [7:0]   err_count
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [N-1:0] MAX_VAL = '1;

  logic [N-1:0]     sync_g;
  logic             sync_vld;
  logic [N-1:0]     sb;
  logic [N-1:0]     diff;
  logic             sample_ok;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [N-1:0]     bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             step_up_q, step_up_d;
  logic             step_down_q, step_down_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             locked_q, locked_d;

  gray_sync #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_in    (gray_in),
    .q_out   (sync_g),
    .vld_out (sync_vld)
  );

  // Decode only once the synchronizer has flushed its reset zeros.
  assign sample_ok = enable & sync_vld;
  assign sb        = N'(gray2bin(MAX_W'(sync_g)));
  assign diff      = sb - bin_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      stab_cnt_q   <= '0;
      prev_q       <= '0;
      bin_q        <= '0;
      bin_valid_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      prev_q       <= prev_d;
      bin_q        <= bin_d;
      bin_valid_q  <= bin_valid_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      locked_q     <= locked_d;
    end
  end

  // Next state, stability counter and previous-sample register.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    prev_d     = prev_q;
    if (sample_ok) begin
      prev_d = sb;
      case (state_q)
        ST_INIT: state_d = ST_TRACK;
        ST_TRACK: begin
          if (diff != '0 && diff != N'(1) && diff != MAX_VAL) begin
            state_d    = ST_RESYNC;
            stab_cnt_d = '0;
          end
        end
        ST_RESYNC: begin
          if (sb == prev_q) begin
            if (stab_cnt_q + CNT_W'(1) == CNT_W'(RESYNC_CNT)) begin
              state_d    = ST_TRACK;
              stab_cnt_d = '0;
            end else begin
              stab_cnt_d = stab_cnt_q + CNT_W'(1);
            end
          end else begin
            stab_cnt_d = '0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Output values registered on the next edge.
  always_comb begin
    bin_d        = bin_q;
    bin_valid_d  = 1'b0;
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    locked_d     = (state_d == ST_TRACK);
    if (sample_ok) begin
      case (state_q)
        ST_INIT: begin
          bin_d       = sb;
          bin_valid_d = 1'b1;
        end
        ST_TRACK: begin
          if (diff == N'(1)) begin
            bin_d       = sb;
            bin_valid_d = 1'b1;
            step_up_d   = 1'b1;
            wrap_d      = (sb == '0);
          end else if (diff == MAX_VAL) begin
            bin_d       = sb;
            bin_valid_d = 1'b1;
            step_down_d = 1'b1;
            wrap_d      = (sb == MAX_VAL);
          end else if (diff != '0) begin
            err_d = 1'b1;
          end
        end
        ST_RESYNC: begin
          if (state_d == ST_TRACK) begin
            bin_d       = sb;
            bin_valid_d = 1'b1;
          end
        end
        default: bin_d = bin_q;
      endcase
    end
    // A same-cycle error outranks the clear.
    if (clear_err) err_sticky_d = 1'b0;
    if (err_d)     err_sticky_d = 1'b1;
  end

`ifdef GRAY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_err && err_d) begin
      err_cnt_d = 8'd1;
    end else if (clear_err) begin
      err_cnt_d = 8'd0;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign bin_out    = bin_q;
  assign bin_valid  = bin_valid_q;
  assign step_up    = step_up_q;
  assign step_down  = step_down_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Bench for gray_rx_decoder: directed scenarios plus a random walk, checked against a
// cycle-level behavioural model of the receive rules (err_count checked under GRAY_RX_ERR_CNT_EN).
module tb_gray_rx_decoder;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int RSYNC = 4;
  localparam int MOD   = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] gray_in;
  logic         clear_err;
  logic [N-1:0] bin_out;
  logic         bin_valid, step_up, step_down, wrap, err, err_sticky, locked;
`ifdef GRAY_RX_ERR_CNT_EN
  logic [7:0]   err_count;
`endif

  gray_rx_decoder #(.N(N), .SYNC_STAGES(SYNC), .RESYNC_CNT(RSYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_down  (step_down),
    .wrap       (wrap),
    .err        (err),
    .err_sticky (err_sticky),
    .locked     (locked)
`ifdef GRAY_RX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a delay line of raw samples plus the receive rules on integers.
  int  m_pipe [SYNC];
  int  m_fill;
  bit  m_locked_mode, m_init_mode;
  int  m_bin, m_prev, m_stab, m_cnt;
  bit  m_sticky;
  bit  e_valid, e_up, e_down, e_wrap, e_err;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b % MOD;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
    m_fill = 0; m_init_mode = 1; m_locked_mode = 0;
    m_bin = 0; m_prev = 0; m_stab = 0; m_cnt = 0; m_sticky = 0;
    e_valid = 0; e_up = 0; e_down = 0; e_wrap = 0; e_err = 0;
  endtask

  task automatic model_edge(input int g, input bit en, input bit clr);
    int sb, d;
    e_valid = 0; e_up = 0; e_down = 0; e_wrap = 0; e_err = 0;
    if (en && m_fill >= SYNC) begin
      sb = g2b(m_pipe[SYNC-1]);
      if (m_init_mode) begin
        m_bin = sb; e_valid = 1; m_init_mode = 0; m_locked_mode = 1;
      end else if (m_locked_mode) begin
        d = (sb - m_bin + MOD) % MOD;
        if (d == 1) begin
          m_bin = sb; e_valid = 1; e_up = 1; e_wrap = (sb == 0);
        end else if (d == MOD - 1) begin
          m_bin = sb; e_valid = 1; e_down = 1; e_wrap = (sb == MOD - 1);
        end else if (d != 0) begin
          e_err = 1; m_locked_mode = 0; m_stab = 0;
        end
      end else begin
        if (sb == m_prev) begin
          m_stab++;
          if (m_stab == RSYNC) begin
            m_bin = sb; e_valid = 1; m_locked_mode = 1; m_stab = 0;
          end
        end else begin
          m_stab = 0;
        end
      end
      m_prev = sb;
    end
    if (clr) begin m_sticky = 0; m_cnt = 0; end
    if (e_err) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
    end
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = g;
    if (m_fill < SYNC) m_fill++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("bin_out",    32'(bin_out),    32'(m_bin));
    check("bin_valid",  32'(bin_valid),  32'(e_valid));
    check("step_up",    32'(step_up),    32'(e_up));
    check("step_down",  32'(step_down),  32'(e_down));
    check("wrap",       32'(wrap),       32'(e_wrap));
    check("err",        32'(err),        32'(e_err));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("locked",     32'(locked),     32'(m_locked_mode && !m_init_mode));
`ifdef GRAY_RX_ERR_CNT_EN
    check("err_count",  32'(err_count),  32'(m_cnt));
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, compare shortly after it.
  task automatic step(input int g, input bit en, input bit clr);
    gray_in   = N'(g);
    enable    = en;
    clear_err = clr;
    @(posedge clk);
    model_edge(g, en, clr);
    #1;
    check_all();
  endtask

  task automatic hold_bin(input int b, input int cycles);
    for (int i = 0; i < cycles; i++) step(b2g(b % MOD), 1'b1, 1'b0);
  endtask

  initial begin
    int cur;
    reset = 1'b1; enable = 1'b0; gray_in = '0; clear_err = 1'b0;
    model_reset();
    #22;
    check_all();
    reset = 1'b0;

    // First sample after reset: gray 0011 loads bin 2 with no classification pulse.
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 1'b0);
    hold_bin(2, 2);

    // Walk down to 0, then the full up sequence including the 15 -> 0 wrap.
    hold_bin(1, 4);
    hold_bin(0, 4);
    for (int b = 1; b <= MOD; b++) hold_bin(b, 4);

    // Down wrap 0 -> 15, then 15 -> 14.
    hold_bin(15, 4);
    hold_bin(14, 4);

    // Climb to 1, jump to 4, wait out the resync, clear the sticky flag.
    hold_bin(15, 4);
    hold_bin(0, 4);
    hold_bin(1, 4);
    hold_bin(4, 8);
    step(b2g(4), 1'b1, 1'b1);
    hold_bin(4, 2);

    // Disabled while the input moves: +1 catch-up, then a larger catch-up.
    for (int i = 0; i < 6; i++) step(b2g(5), 1'b0, 1'b0);
    hold_bin(5, 3);
    for (int b = 6; b <= 8; b++) begin
      step(b2g(b), 1'b0, 1'b0);
      step(b2g(b), 1'b0, 1'b0);
    end
    hold_bin(8, 2);

    // Async reset while resyncing: outputs must drop with no clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b0;
    hold_bin(8, 5);

    // Three illegal jumps with recovery, then clear; then err coinciding with clear.
    hold_bin(11, 6);
    hold_bin(2, 6);
    hold_bin(7, 6);
    step(b2g(7), 1'b1, 1'b1);
    hold_bin(7, 2);
    step(b2g(12), 1'b1, 1'b0);
    step(b2g(12), 1'b1, 1'b0);
    step(b2g(12), 1'b1, 1'b1);
    hold_bin(12, 6);

    // Random walk: mostly single steps, occasional jumps, gaps in enable, sporadic clears.
    cur = 12;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 35)      cur = (cur + 1) % MOD;
      else if (r < 65) cur = (cur + MOD - 1) % MOD;
      else if (r < 72) cur = int'($urandom_range(0, MOD - 1));
      step(b2g(cur), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receiving end of the N-bit Gray counter interface.
- Samples a Gray count, typically produced in another clock domain, through a synchronizer and converts it to binary.
- Classifies each change as a step up, step down or illegal jump; reports wrap-around; tracks lock.
- Feeds binary counts to downstream logic such as FIFO pointer compare and event counters.

Parameters:
- N, 4, count width in bits; legal range 2..16.
- SYNC_STAGES, 2, number of synchronizer flops on gray_in; legal range 2..4.
- RESYNC_CNT, 4, consecutive stable enabled samples needed to re-lock after an error; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  sample enable; when low, the decode stage holds its state.
- gray_in  input  N  Gray-coded count; may be asynchronous to clk.
- clear_err  input  1  synchronous clear of err_sticky (and err_count when compiled in).
- bin_out  output  N  registered binary equivalent of the last accepted sample.
- bin_valid  output  1  one-cycle pulse when bin_out takes a new value.
- step_up  output  1  one-cycle pulse: new value = old + 1 mod 2^N.
- step_down  output  1  one-cycle pulse: new value = old - 1 mod 2^N.
- wrap  output  1  one-cycle pulse on max→0 (up) or 0→max (down).
- err  output  1  one-cycle pulse on an illegal jump.
- err_sticky  output  1  set by err; cleared only by clear_err or reset.
- locked  output  1  high while in the TRACK state.

Behaviour:
- Reset: all sync flops = 0; FSM = INIT; all outputs = 0.
- Synchronizer:
  - SYNC_STAGES flops always clock, independent of enable.
  - sync_g is the last stage.
- Decode stage:
  - Only acts on cycles with enable = 1.
  - sb = gray2bin(sync_g), where b[N-1] = g[N-1] and b[i] = b[i+1] ^ g[i].
  - d = (sb - bin_out) mod 2^N, computed N bits wide.
- Latency: an enabled, stable change on gray_in appears on bin_out and the pulses SYNC_STAGES+1 clk edges later.
- FSM state INIT:
  - First enabled cycle loads bin_out = sb, pulses bin_valid, goes to TRACK.
  - No step, wrap or err pulse on this load.
- FSM state TRACK:
  - d = 0: no action.
  - d = 1: bin_out = sb; pulse bin_valid and step_up; also pulse wrap if sb = 0.
  - d = 2^N - 1: bin_out = sb; pulse bin_valid and step_down; also pulse wrap if sb = 2^N - 1.
  - Any other d: pulse err, set err_sticky, go to RESYNC; bin_out holds; stab_cnt = 0.
- FSM state RESYNC:
  - locked = 0.
  - Each enabled sample equal to the previous sample increments stab_cnt; any difference resets it to 0.
  - When stab_cnt reaches RESYNC_CNT: bin_out = sb, pulse bin_valid, go to TRACK. No step pulse.
  - A further change during RESYNC does not re-pulse err.
- enable = 0: the FSM, bin_out, stab_cnt and the previous-sample register all hold, and no pulses fire.
- clear_err:
  - Clears err_sticky on the next edge.
  - If err fires in the same cycle, err wins and err_sticky stays 1.
- Reset mid-operation returns to INIT immediately, asynchronously. The first sample after reset is never flagged.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: GRAY_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0].
  - Increments on each err pulse and saturates at 255.
  - Cleared by reset or clear_err; if err and clear_err coincide, err_count = 1.
- Undefined: port and logic absent; other behaviour identical.

Decomposition:
- Shared package gray_pkg:
  - FSM state typedef (INIT, TRACK, RESYNC).
  - gray2bin and bin2gray functions, parameterized by width, shared with the counter side.
- One sub-module, gray_sync: an N-bit, SYNC_STAGES-deep synchronizer with asynchronous reset to 0.
- The FSM and classification logic stay in the top level.

Test Plan (N=4, SYNC_STAGES=2, RESYNC_CNT=4):
- Reset release, gray_in = 0011, enable = 1:
  - After 3 edges, bin_out = 0010, bin_valid pulses, locked = 1.
  - No step_up, step_down or err.
- Drive the full up sequence 0000→0001→0011…→1000→0000, each value held 4 cycles:
  - 16 step_up pulses.
  - bin_out follows 0..15.
  - wrap pulses once, on 15→0.
- Down sequence 0000→1000 (bin 0→15):
  - step_down and wrap pulse.
  - Next value 1001 gives bin 14 and step_down only.
- Jump 0001→0110 (bin 1→4):
  - err pulses; err_sticky = 1; locked = 0; bin_out stays 1.
  - After 4 stable enabled samples: bin_out = 4, bin_valid pulses, locked = 1.
  - Pulse clear_err: err_sticky = 0.
- enable = 0 while gray_in steps: no pulses, bin_out frozen. On re-enable, the catch-up is classified normally (+1 gives step_up; larger gives err).
- Assert reset during RESYNC:
  - Outputs go to 0 asynchronously; FSM = INIT.
  - With GRAY_RX_ERR_CNT_EN: 3 errors give err_count = 3; clear_err gives 0.
